// File: rtl/dmem_debug_arbiter_if.sv
// Bundle of the pipeline MEM-stage, debug-dump and data-RAM signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline/debug/RAM side.
interface dmem_debug_arbiter_if #(
    parameter int LEN         = 32,
    parameter int NB_MEM_ADDR = 5,
    parameter int NB_CTRL_M   = 3
);
    logic [LEN-1:0]         i_pipe_addr;
    logic [LEN-1:0]         i_pipe_write_data;
    logic [NB_CTRL_M-1:0]   i_pipe_ctrl_mem;
    logic [LEN-1:0]         o_pipe_read_data;
    logic                   o_pipe_stall;

    // Dump beat: o_dbg_valid rises with data/addr and holds them steady until a cycle with
    // i_dbg_ready=1; the beat transfers on that rising clock edge.
    logic                   i_dbg_dump_req;
    logic                   o_dbg_valid;
    logic                   i_dbg_ready;
    logic [LEN-1:0]         o_dbg_data;
    logic [NB_MEM_ADDR-1:0] o_dbg_addr;
    logic                   o_dbg_done;

    logic [NB_MEM_ADDR-1:0] o_mem_addr;
    logic [LEN-1:0]         o_mem_wdata;
    logic                   o_mem_we;
    logic                   o_mem_re;
    logic [LEN-1:0]         i_mem_rdata;

    logic [1:0]             o_fsm_state;

    modport slave (
        input  i_pipe_addr, i_pipe_write_data, i_pipe_ctrl_mem,
        output o_pipe_read_data, o_pipe_stall,
        input  i_dbg_dump_req, i_dbg_ready,
        output o_dbg_valid, o_dbg_data, o_dbg_addr, o_dbg_done,
        output o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re,
        input  i_mem_rdata,
        output o_fsm_state
    );

    modport master (
        output i_pipe_addr, i_pipe_write_data, i_pipe_ctrl_mem,
        input  o_pipe_read_data, o_pipe_stall,
        output i_dbg_dump_req, i_dbg_ready,
        input  o_dbg_valid, o_dbg_data, o_dbg_addr, o_dbg_done,
        input  o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re,
        output i_mem_rdata,
        input  o_fsm_state
    );
endinterface

// File: rtl/dmem_debug_arbiter.sv
// Shares the data-RAM port between the pipeline MEM stage and a debug unit that dumps
// the whole memory word by word, freezing the pipeline for the duration of the dump.
module dmem_debug_arbiter #(
    parameter int LEN         = 32,
    parameter int RAM_DEPTH   = 21,
    parameter int NB_MEM_ADDR = 5,
    parameter int NB_CTRL_M   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    dmem_debug_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

    state_t                 r_state, w_next;
    logic [NB_MEM_ADDR-1:0] r_cnt, w_cnt_next;
    logic                   r_load_valid;
    logic                   r_resp_first;
    logic [LEN-1:0]         r_dbg_data;

    logic                   w_in_range, w_mem_read, w_mem_write, w_hs;
    logic [NB_MEM_ADDR-1:0] w_mem_addr;
    logic                   w_mem_we, w_mem_re;
    logic                   w_unused;

    assign w_in_range  = bus.i_pipe_addr < LEN'(RAM_DEPTH);
    assign w_mem_read  = bus.i_pipe_ctrl_mem[1];
    assign w_mem_write = bus.i_pipe_ctrl_mem[0];
    assign w_hs        = (r_state == RESP) && bus.i_dbg_ready;
    // Branch travels on the same bus but has no meaning for memory access.
    assign w_unused    = bus.i_pipe_ctrl_mem[2];

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_mem_addr = bus.i_pipe_addr[NB_MEM_ADDR-1:0];
        w_mem_we   = 1'b0;
        w_mem_re   = 1'b0;
        case (r_state)
            IDLE: begin
                w_mem_we = w_mem_write && w_in_range;
                w_mem_re = w_mem_read && w_in_range;
                if (bus.i_dbg_dump_req) begin
                    w_next     = READ;
                    w_cnt_next = '0;
                end
            end
            READ: begin
                w_mem_addr = r_cnt;
                w_mem_re   = 1'b1;
                w_next     = RESP;
            end
            RESP: begin
                if (w_hs) begin
                    if (r_cnt == NB_MEM_ADDR'(RAM_DEPTH - 1)) begin
                        w_next = DONE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                        w_next     = READ;
                    end
                end
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_load_valid <= 1'b0;
            r_resp_first <= 1'b0;
            r_dbg_data   <= '0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_load_valid <= (r_state == IDLE) && w_mem_read && w_in_range;
            r_resp_first <= (r_state == READ);
            if (r_resp_first) begin
                r_dbg_data <= bus.i_mem_rdata;
            end
        end
    end

    // RAM data arrives during the first RESP cycle; it is forwarded then and held from
    // the register afterwards so a stalled beat stays stable whatever the RAM output does.
    assign bus.o_dbg_data       = r_resp_first ? bus.i_mem_rdata : r_dbg_data;
    assign bus.o_dbg_addr       = r_cnt;
    assign bus.o_dbg_valid      = (r_state == RESP);
    assign bus.o_dbg_done       = (r_state == DONE);
    assign bus.o_pipe_stall     = (r_state != IDLE);
    assign bus.o_pipe_read_data = (r_load_valid && (r_state == IDLE)) ? bus.i_mem_rdata : '0;
    assign bus.o_mem_addr       = w_mem_addr;
    assign bus.o_mem_wdata      = bus.i_pipe_write_data;
    assign bus.o_mem_we         = w_mem_we;
    assign bus.o_mem_re         = w_mem_re;
    assign bus.o_fsm_state      = r_state;
endmodule

// File: tb/tb_dmem_debug_arbiter.sv
// Bench for dmem_debug_arbiter: RAM model, directed pipeline vectors and a dump scoreboard.
module tb_dmem_debug_arbiter;
    localparam int LEN = 32;
    localparam int NB  = 5;
    localparam int DEPTH = 21;

    logic clk;
    logic rst_n;
    logic ram_load;

    dmem_debug_arbiter_if #(.LEN(LEN), .NB_MEM_ADDR(NB), .NB_CTRL_M(3)) bus ();

    dmem_debug_arbiter #(.LEN(LEN), .RAM_DEPTH(DEPTH), .NB_MEM_ADDR(NB), .NB_CTRL_M(3)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus.slave)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-chosen RAM image: word i = D000_iiii style pattern
    function automatic logic [31:0] img(int i);
        return 32'hD000_0000 | (32'(i) << 8) | 32'(i);
    endfunction

    // Synchronous-read RAM model
    logic [31:0] ram [32];
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 32; i++) ram[i] <= img(i);
        end else begin
            if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
            if (bus.o_mem_re) bus.i_mem_rdata <= ram[bus.o_mem_addr];
        end
    end

    // Scoreboard
    logic [31:0] exp_ram [32];
    logic [NB+LEN-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every accepted dump beat is compared with the head of the queue
    always @(negedge clk) begin
        #1;
        if (rst_n && bus.o_dbg_valid && bus.i_dbg_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL dump_beat_unexpected: got addr %0d data %h expected none",
                         bus.o_dbg_addr, bus.o_dbg_data);
            end else begin
                logic [NB+LEN-1:0] e;
                e = exp_q.pop_front();
                chk("dump_addr", 64'(bus.o_dbg_addr), 64'(e[NB+LEN-1:LEN]));
                chk("dump_data", 64'(bus.o_dbg_data), 64'(e[LEN-1:0]));
            end
        end
    end

    // Drivers
    task automatic pipe_drive(logic [2:0] ctrl, logic [31:0] addr, logic [31:0] data);
        bus.i_pipe_ctrl_mem   = ctrl;
        bus.i_pipe_addr       = addr;
        bus.i_pipe_write_data = data;
    endtask

    // Called at a negedge; returns at the negedge after the request edge
    task automatic issue_dump();
        bus.i_dbg_dump_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({NB'(i), exp_ram[i]});
        @(negedge clk);
        bus.i_dbg_dump_req = 1'b0;
    endtask

    task automatic wait_done(string name);
        int seen;
        seen = 0;
        for (int c = 0; c < 300 && seen == 0; c++) begin
            if (bus.o_dbg_done) seen = 1;
            else @(negedge clk);
        end
        chk(name, 64'(seen), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int hold;
        int found;
        rst_n = 1'b0;
        ram_load = 1'b1;
        bus.i_dbg_dump_req = 1'($urandom_range(0, 1));
        bus.i_dbg_ready    = 1'($urandom_range(0, 1));
        pipe_drive(3'($urandom_range(0, 7)), $urandom, $urandom);
        for (int i = 0; i < 32; i++) exp_ram[i] = img(i);

        // Reset with random inputs
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(bus.o_dbg_valid), 64'd0);
        chk("rst_done",  64'(bus.o_dbg_done), 64'd0);
        chk("rst_stall", 64'(bus.o_pipe_stall), 64'd0);
        chk("rst_data",  64'(bus.o_dbg_data), 64'd0);
        chk("rst_addr",  64'(bus.o_dbg_addr), 64'd0);
        chk("rst_rdata", 64'(bus.o_pipe_read_data), 64'd0);
        ram_load = 1'b0;
        bus.i_dbg_dump_req = 1'b0;
        bus.i_dbg_ready = 1'b1;
        pipe_drive(3'b000, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Passthrough store then load
        pipe_drive(3'b001, 32'd5, 32'hF6F6_F6F6);
        #1;
        chk("st_we",   64'(bus.o_mem_we), 64'd1);
        chk("st_addr", 64'(bus.o_mem_addr), 64'd5);
        chk("st_re",   64'(bus.o_mem_re), 64'd0);
        exp_ram[5] = 32'hF6F6_F6F6;
        @(negedge clk);
        pipe_drive(3'b010, 32'd5, 32'd0);
        #1;
        chk("ld_re", 64'(bus.o_mem_re), 64'd1);
        @(negedge clk);
        pipe_drive(3'b110, 32'd0, 32'd0);
        #1;
        chk("ld5_data", 64'(bus.o_pipe_read_data), 64'hF6F6_F6F6);
        @(negedge clk);
        pipe_drive(3'b000, 32'd0, 32'd0);
        #1;
        chk("ld0_data", 64'(bus.o_pipe_read_data), 64'hD000_0000);
        @(negedge clk);
        #1;
        chk("no_ld_data", 64'(bus.o_pipe_read_data), 64'd0);

        // Out of range
        @(negedge clk);
        pipe_drive(3'b001, 32'd21, 32'h1234_5678);
        #1;
        chk("oor_st_we", 64'(bus.o_mem_we), 64'd0);
        @(negedge clk);
        pipe_drive(3'b010, 32'd21, 32'd0);
        #1;
        chk("oor_ld_re", 64'(bus.o_mem_re), 64'd0);
        @(negedge clk);
        pipe_drive(3'b000, 32'd0, 32'd0);
        #1;
        chk("oor_ld_data", 64'(bus.o_pipe_read_data), 64'd0);
        @(negedge clk);

        // Full dump with ready held high, pipeline hammering store+load+branch meanwhile
        issue_dump();
        for (int k = 1; k <= 44; k++) begin
            if (k == 1)  pipe_drive(3'b111, 32'd7, 32'hDEAD_BEEF);
            if (k == 43) pipe_drive(3'b000, 32'd0, 32'd0);
            #1;
            chk($sformatf("dump_stall_t%0d", k), 64'(bus.o_pipe_stall), 64'(k <= 43));
            chk($sformatf("dump_done_t%0d", k),  64'(bus.o_dbg_done),   64'(k == 43));
            if (k <= 43) begin
                chk($sformatf("dump_we_t%0d", k), 64'(bus.o_mem_we), 64'd0);
                chk($sformatf("dump_prd_t%0d", k), 64'(bus.o_pipe_read_data), 64'd0);
            end
            if (k == 44) chk("dump_idle_t44", 64'(bus.o_fsm_state), 64'd0);
            @(negedge clk);
        end
        chk("dump1_q_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure on word 3 for 5 cycles
        hold = 0;
        issue_dump();
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            if (bus.o_dbg_done) begin
                found = 1;
            end else begin
                if (bus.o_dbg_valid && bus.o_dbg_addr == NB'(3) && hold < 5) begin
                    bus.i_dbg_ready = 1'b0;
                    chk("bp_valid", 64'(bus.o_dbg_valid), 64'd1);
                    chk("bp_addr",  64'(bus.o_dbg_addr), 64'd3);
                    chk("bp_data",  64'(bus.o_dbg_data), 64'(exp_ram[3]));
                    hold++;
                end else begin
                    bus.i_dbg_ready = 1'b1;
                end
                @(negedge clk);
            end
        end
        bus.i_dbg_ready = 1'b1;
        chk("bp_done_seen", 64'(found), 64'd1);
        chk("bp_hold_cycles", 64'(hold), 64'd5);
        chk("bp_q_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);

        // Abort at word 10, then restart from 0
        issue_dump();
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (bus.o_dbg_valid && bus.o_dbg_addr == NB'(10)) found = 1;
            else @(negedge clk);
        end
        chk("abort_reached_w10", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(bus.o_dbg_valid), 64'd0);
        chk("abort_stall", 64'(bus.o_pipe_stall), 64'd0);
        chk("abort_done",  64'(bus.o_dbg_done), 64'd0);
        chk("abort_addr",  64'(bus.o_dbg_addr), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_abort_done",  64'(bus.o_dbg_done), 64'd0);
            chk("post_abort_stall", 64'(bus.o_pipe_stall), 64'd0);
        end
        issue_dump();
        wait_done("restart_done_seen");
        chk("restart_q_empty", 64'(exp_q.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_debug_arbiter.md
DMEM_DEBUG_ARBITER -- requirements
Module: dmem_debug_arbiter

Interface
REQ-001 Parameter LEN, 32, data word width.
REQ-002 Parameter RAM_DEPTH, 21, number of data-memory words.
REQ-003 Parameter NB_MEM_ADDR, 5, memory word-address width, with 2^NB_MEM_ADDR >= RAM_DEPTH.
REQ-004 Parameter NB_CTRL_M, 3, MEM-stage control width, [Branch, MemRead, MemWrite].
REQ-005 Port i_clk, input, 1, single clock; all state updates on rising edge.
REQ-006 Port i_rst, input, 1, reset; asynchronous, active-low.
REQ-007 Port i_pipe_addr, input, LEN, MEM-stage ALU result used as word address.
REQ-008 Port i_pipe_write_data, input, LEN, MEM-stage store data.
REQ-009 Port i_pipe_ctrl_mem, input, NB_CTRL_M, MEM-stage control bus.
REQ-010 Port o_pipe_read_data, output, LEN, load data returned to the pipeline.
REQ-011 Port o_pipe_stall, output, 1, pipeline freeze request.
REQ-012 Port i_dbg_dump_req, input, 1, debug-unit request to dump the whole data memory.
REQ-013 Port o_dbg_valid, output, 1, dump word valid.
REQ-014 Port i_dbg_ready, input, 1, debug unit accepts the dump word.
REQ-015 Port o_dbg_data, output, LEN, dump word.
REQ-016 Port o_dbg_addr, output, NB_MEM_ADDR, address of the dump word.
REQ-017 Port o_dbg_done, output, 1, one-cycle end-of-dump pulse.
REQ-018 Ports o_mem_addr (NB_MEM_ADDR), o_mem_wdata (LEN), o_mem_we (1), o_mem_re (1), outputs; i_mem_rdata (LEN), input; data-RAM port, read data valid one cycle after o_mem_re.

Function
REQ-019 The FSM SHALL have states IDLE, READ, RESP and DONE.
REQ-020 In IDLE, the RAM port SHALL be driven combinationally from the pipeline: o_mem_addr = i_pipe_addr[NB_MEM_ADDR-1:0], o_mem_we = MemWrite, o_mem_re = MemRead, o_mem_wdata = i_pipe_write_data.
REQ-021 A pipeline address >= RAM_DEPTH SHALL suppress o_mem_we and o_mem_re; the load then returns 0.
REQ-022 o_pipe_read_data SHALL equal i_mem_rdata in the cycle after an in-range IDLE load, and 0 otherwise.
REQ-023 IDLE with i_dbg_dump_req=1 SHALL complete that cycle's pipeline access, clear the address counter to 0 and go to READ.
REQ-024 READ SHALL drive o_mem_re=1, o_mem_we=0, o_mem_addr=counter, then go to RESP.
REQ-025 RESP SHALL register i_mem_rdata into o_dbg_data on entry and hold o_dbg_valid=1 with o_dbg_data and o_dbg_addr stable until i_dbg_valid&&i_dbg_ready... i.e. until o_dbg_valid and i_dbg_ready are both 1.
REQ-026 On a RESP handshake, counter == RAM_DEPTH-1 SHALL go to DONE; otherwise the counter SHALL increment and the FSM SHALL go to READ.
REQ-027 DONE SHALL assert o_dbg_done for exactly one cycle, then go to IDLE.
REQ-028 o_pipe_stall SHALL be 1 in READ, RESP and DONE, and 0 in IDLE.
REQ-029 In any non-IDLE state, pipeline MemWrite/MemRead SHALL be ignored and o_pipe_read_data SHALL be 0.
REQ-030 i_dbg_dump_req SHALL be ignored outside IDLE; no request is queued.
REQ-031 Branch (i_pipe_ctrl_mem[2]) SHALL not affect this block.

Reset
REQ-032 i_rst=0 SHALL immediately force IDLE, counter 0, and o_dbg_valid, o_dbg_done, o_pipe_stall, o_dbg_data, o_dbg_addr and the registered load-valid flag to 0, regardless of clock.
REQ-033 A reset during a dump SHALL abort it without asserting o_dbg_done; the next request SHALL restart at address 0.

Verification
REQ-034 Reset: i_rst=0 with random inputs -> all registered outputs 0 and o_pipe_stall=0.
REQ-035 Passthrough: store ctrl 3'b001, addr 5, data F6F6F6F6 -> o_mem_we=1 and o_mem_addr=5; then load ctrl 3'b010, addr 5 -> o_pipe_read_data=F6F6F6F6 on the next cycle.
REQ-036 Out of range: store to addr 21 -> o_mem_we=0; load from addr 21 -> o_pipe_read_data=0.
REQ-037 Full dump, i_dbg_ready=1, request at cycle t -> 21 beats with addresses 0..20 and data matching the RAM image; o_pipe_stall=1 during t+1..t+43; o_dbg_done=1 only at t+43; IDLE at t+44.
REQ-038 Backpressure: i_dbg_ready=0 for 5 cycles at word 3 -> o_dbg_valid=1, o_dbg_addr=3 and o_dbg_data held stable; no address is skipped.
REQ-039 Abort: i_rst=0 at word 10 -> o_dbg_valid=0 and o_pipe_stall=0 with no o_dbg_done; a new request restarts the dump at o_dbg_addr=0.
